// File: rtl/rf_commit_queue_pkg.sv
// Shared constants and FSM encodings for the register-file commit queue.
package rf_commit_queue_pkg;
    localparam int REG_NUM_WIDTH  = 5;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam logic [ROB_SIZE_WIDTH:0] NO_DEP = '1;

    typedef enum logic [1:0] {
        CQ_RUN   = 2'd0,
        CQ_DRAIN = 2'd1,
        CQ_FLUSH = 2'd2
    } cq_state_t;
endpackage

// File: rtl/rf_commit_queue_if.sv
// Commit-lane / RF-write-port bundle between the ROB, the commit queue and the register file.
interface rf_commit_queue_if #(
    parameter int DEPTH = 4,
    parameter int REG_W = 5,
    parameter int TAG_W = 5
);
    import rf_commit_queue_pkg::*;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Lanes are consumed on a rising clk_in only when rdy_in && cq_ready_out; valid lanes outside
    // that window are ignored. rf_valid_out is a one-cycle write strobe with no back-pressure.
    logic             rdy_in;
    logic             c0_valid_in;
    logic [REG_W-1:0] c0_rd_in;
    logic [31:0]      c0_value_in;
    logic [TAG_W-1:0] c0_tag_in;
    logic             c1_valid_in;
    logic [REG_W-1:0] c1_rd_in;
    logic [31:0]      c1_value_in;
    logic [TAG_W-1:0] c1_tag_in;
    logic             flush_req_in;
    logic             cq_ready_out;
    logic             rf_valid_out;
    logic [REG_W-1:0] rf_rd_out;
    logic [31:0]      rf_value_out;
    logic [TAG_W-1:0] rf_tag_out;
    logic             rf_flush_out;
    logic             busy_out;
    logic [CNT_W-1:0] count_out;
    cq_state_t        state_dbg;

    modport master (
        output rdy_in, c0_valid_in, c0_rd_in, c0_value_in, c0_tag_in,
               c1_valid_in, c1_rd_in, c1_value_in, c1_tag_in, flush_req_in,
        input  cq_ready_out, rf_valid_out, rf_rd_out, rf_value_out, rf_tag_out,
               rf_flush_out, busy_out, count_out, state_dbg
    );

    modport slave (
        input  rdy_in, c0_valid_in, c0_rd_in, c0_value_in, c0_tag_in,
               c1_valid_in, c1_rd_in, c1_value_in, c1_tag_in, flush_req_in,
        output cq_ready_out, rf_valid_out, rf_rd_out, rf_value_out, rf_tag_out,
               rf_flush_out, busy_out, count_out, state_dbg
    );
endinterface

// File: rtl/rf_commit_queue_fifo.sv
// Two-write / one-read circular buffer with occupancy count; write 1 lands behind write 0.
module cq_fifo_2w1r #(
    parameter int DEPTH = 4,
    parameter int W = 42,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr0_en,
    input  logic [W-1:0]     wr0_data,
    input  logic             wr1_en,
    input  logic [W-1:0]     wr1_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr] <= wr0_data;
        if (wr1_en) mem[wr_ptr + PTR_W'(1)] <= wr1_data;
    end

    assign rd_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count} + (CNT_W+1)'(wr0_en) + (CNT_W+1)'(wr1_en))
            <= ((CNT_W+1)'(DEPTH) + (CNT_W+1)'(rd_en)));
endmodule

// File: rtl/rf_commit_queue.sv
// Commit queue between ROB retirement and the single RF write port, with flush sequencing.
// Optional RF_COMMIT_QUEUE_BYPASS_EN: a lone write into an idle, empty queue goes straight out.
module rf_commit_queue
    import rf_commit_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REG_W = REG_NUM_WIDTH,
    parameter int TAG_W = ROB_SIZE_WIDTH + 1
) (
    input logic clk_in,
    input logic rst_n_in,
    rf_commit_queue_if.slave cq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = REG_W + 32 + TAG_W;

    cq_state_t        state_q, state_d;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head, ent0, ent1, push_data_a, out_q, byp_ent;
    logic             cq_ready, take, keep0, keep1, push_a, push_b, pop, byp, rf_valid_q;

    assign cq_ready = (state_q == CQ_RUN) && (count <= CNT_W'(DEPTH - 2));
    assign take     = cq.rdy_in && cq_ready;
    assign keep0    = take && cq.c0_valid_in && (cq.c0_rd_in != '0);
    assign keep1    = take && cq.c1_valid_in && (cq.c1_rd_in != '0);
    assign ent0     = {cq.c0_rd_in, cq.c0_value_in, cq.c0_tag_in};
    assign ent1     = {cq.c1_rd_in, cq.c1_value_in, cq.c1_tag_in};

`ifdef RF_COMMIT_QUEUE_BYPASS_EN
    // The registered stage must be idle too, otherwise two writes would collide on the port.
    assign byp     = take && (count == '0) && !rf_valid_q && (keep0 ^ keep1);
    assign byp_ent = keep0 ? ent0 : ent1;
`else
    assign byp     = 1'b0;
    assign byp_ent = '0;
`endif

    // A dropped lane 0 lets lane 1 take the first free slot.
    assign push_a      = (keep0 || keep1) && !byp;
    assign push_b      = keep0 && keep1;
    assign push_data_a = keep0 ? ent0 : ent1;
    assign pop         = cq.rdy_in && (count != '0);

    cq_fifo_2w1r #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .wr0_en   (push_a),
        .wr0_data (push_data_a),
        .wr1_en   (push_b),
        .wr1_data (ent1),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CQ_RUN:   if (cq.rdy_in && cq.flush_req_in) state_d = CQ_DRAIN;
            CQ_DRAIN: if (cq.rdy_in && (count == '0))   state_d = CQ_FLUSH;
            CQ_FLUSH: if (cq.rdy_in)                    state_d = CQ_RUN;
            default:                                     state_d = CQ_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= CQ_RUN;
        else           state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rf_valid_q <= 1'b0;
            out_q      <= {{REG_W{1'b0}}, 32'd0, {TAG_W{1'b1}}};
        end else if (cq.rdy_in) begin
            rf_valid_q <= pop;
            if (pop) out_q <= head;
        end
    end

    assign cq.cq_ready_out = cq_ready;
    assign cq.rf_valid_out = rf_valid_q || byp;
    assign {cq.rf_rd_out, cq.rf_value_out, cq.rf_tag_out} = byp ? byp_ent : out_q;
    assign cq.rf_flush_out = (state_q == CQ_FLUSH);
    assign cq.busy_out     = (state_q != CQ_RUN);
    assign cq.count_out    = count;
    assign cq.state_dbg    = state_q;

    a_c1_needs_c0: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        cq.c1_valid_in |-> cq.c0_valid_in);
endmodule

// File: tb/tb_rf_commit_queue.sv
// Self-checking bench for rf_commit_queue: directed vector table, corner sequences, random vs queue model.
module tb_rf_commit_queue;
    import rf_commit_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int REG_W = 5;
    localparam int TAG_W = 5;
    localparam int ENT_W = REG_W + 32 + TAG_W;

    logic clk_in;
    logic rst_n_in;
    int   n_pass = 0;
    int   n_total = 0;

    rf_commit_queue_if #(.DEPTH(DEPTH), .REG_W(REG_W), .TAG_W(TAG_W)) cq_if ();

    rf_commit_queue #(.DEPTH(DEPTH), .REG_W(REG_W), .TAG_W(TAG_W)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .cq       (cq_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        bit c0v; int c0rd; int c0val; int c0tag;
        bit c1v; int c1rd; int c1val; int c1tag;
        bit fl;
        bit ev; int erd; int evl; int etg; int ecnt; bit erdy; bit ebusy; bit efl;
    } vec_t;
    vec_t tbl[$];

    // Behavioural reference: an ordered list of pending writes plus the flush bookkeeping.
    logic [ENT_W-1:0] exp_q[$];
    bit               m_pending, m_pulse, m_valid;
    logic [ENT_W-1:0] m_ent;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input bit c0v, input int c0rd, input int c0val, input int c0tag,
                         input bit c1v, input int c1rd, input int c1val, input int c1tag,
                         input bit fl, input bit rdy);
        cq_if.c0_valid_in  = c0v;
        cq_if.c0_rd_in     = REG_W'(c0rd);
        cq_if.c0_value_in  = 32'(c0val);
        cq_if.c0_tag_in    = TAG_W'(c0tag);
        cq_if.c1_valid_in  = c1v;
        cq_if.c1_rd_in     = REG_W'(c1rd);
        cq_if.c1_value_in  = 32'(c1val);
        cq_if.c1_tag_in    = TAG_W'(c1tag);
        cq_if.flush_req_in = fl;
        cq_if.rdy_in       = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    function automatic bit m_ready();
        return !m_pending && !m_pulse && (DEPTH - exp_q.size() >= 2);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_pending = 0;
        m_pulse   = 0;
        m_valid   = 0;
    endtask

    task automatic model_edge();
        int pre_size;
        bit ready;
        if (!cq_if.rdy_in) return;
        pre_size = exp_q.size();
        ready    = m_ready();
        m_valid  = (pre_size > 0);
        if (m_valid) m_ent = exp_q.pop_front();
        if (ready && cq_if.c0_valid_in && cq_if.c0_rd_in != 0)
            exp_q.push_back({cq_if.c0_rd_in, cq_if.c0_value_in, cq_if.c0_tag_in});
        if (ready && cq_if.c1_valid_in && cq_if.c1_rd_in != 0)
            exp_q.push_back({cq_if.c1_rd_in, cq_if.c1_value_in, cq_if.c1_tag_in});
        if (m_pulse) m_pulse = 0;
        else if (m_pending) begin
            if (pre_size == 0) begin
                m_pending = 0;
                m_pulse   = 1;
            end
        end else if (cq_if.flush_req_in) m_pending = 1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rf_valid"}, 64'(cq_if.rf_valid_out), 64'(m_valid));
        if (m_valid)
            check({tag, ".rf_write"}, 64'({cq_if.rf_rd_out, cq_if.rf_value_out, cq_if.rf_tag_out}), 64'(m_ent));
        check({tag, ".count"}, 64'(cq_if.count_out), 64'(exp_q.size()));
        check({tag, ".cq_ready"}, 64'(cq_if.cq_ready_out), 64'(m_ready()));
        check({tag, ".busy"}, 64'(cq_if.busy_out), 64'(m_pending || m_pulse));
        check({tag, ".rf_flush"}, 64'(cq_if.rf_flush_out), 64'(m_pulse));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk_in);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        idle();
        rst_n_in = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic row(input bit c0v, input int c0rd, input int c0val, input int c0tag,
                       input bit c1v, input int c1rd, input int c1val, input int c1tag, input bit fl,
                       input bit ev, input int erd, input int evl, input int etg,
                       input int ecnt, input bit erdy, input bit ebusy, input bit efl);
        vec_t v;
        v = '{c0v, c0rd, c0val, c0tag, c1v, c1rd, c1val, c1tag, fl, ev, erd, evl, etg, ecnt, erdy, ebusy, efl};
        tbl.push_back(v);
    endtask

    initial begin
        do_reset();
        check("reset.rf_valid", 64'(cq_if.rf_valid_out), 64'(0));
        check("reset.rf_rd", 64'(cq_if.rf_rd_out), 64'(0));
        check("reset.rf_value", 64'(cq_if.rf_value_out), 64'(0));
        check("reset.rf_tag", 64'(cq_if.rf_tag_out), 64'(NO_DEP));
        check("reset.count", 64'(cq_if.count_out), 64'(0));
        check("reset.cq_ready", 64'(cq_if.cq_ready_out), 64'(1));
        check("reset.busy", 64'(cq_if.busy_out), 64'(0));
        check("reset.rf_flush", 64'(cq_if.rf_flush_out), 64'(0));

        // Inputs for one cycle, then the outputs expected right after that clock edge.
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 5, 'h1234, 3,       0, 0, 0, 0,          0,  0, 0, 0, 0,           1, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 5, 'h1234, 3,      0, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 1, 'hA, 1,          1, 2, 'hB, 2,        0,  0, 0, 0, 0,           2, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 1, 'hA, 1,         1, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 2, 'hB, 2,         0, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 3, 'h30, 4,         1, 4, 'h40, 5,       0,  0, 0, 0, 0,           2, 1, 0, 0);
        row(1, 6, 'h60, 6,         1, 8, 'h80, 7,       0,  1, 3, 'h30, 4,        3, 0, 0, 0);
        row(1, 9, 'h90, 9,         0, 0, 0, 0,          0,  1, 4, 'h40, 5,        2, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 6, 'h60, 6,        1, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 8, 'h80, 7,        0, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 0, 'hDEAD, 1,       0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 0, 'h5, 1,          1, 10, 'hA0, 8,      0,  0, 0, 0, 0,           1, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 10, 'hA0, 8,       0, 1, 0, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          1,  0, 0, 0, 0,           0, 0, 1, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 0, 1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);
        row(1, 11, 'hB1, 1,        1, 12, 'hB2, 2,      0,  0, 0, 0, 0,           2, 1, 0, 0);
        row(1, 13, 'hB3, 3,        0, 0, 0, 0,          0,  1, 11, 'hB1, 1,       2, 1, 0, 0);
        row(1, 7, 'h77, 7,         0, 0, 0, 0,          1,  1, 12, 'hB2, 2,       2, 0, 1, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          1,  1, 13, 'hB3, 3,       1, 0, 1, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  1, 7, 'h77, 7,        0, 0, 1, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 0, 1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,          0,  0, 0, 0, 0,           0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].c0v, tbl[i].c0rd, tbl[i].c0val, tbl[i].c0tag,
                  tbl[i].c1v, tbl[i].c1rd, tbl[i].c1val, tbl[i].c1tag, tbl[i].fl, 1);
            @(posedge clk_in);
            #1;
            check({t, ".rf_valid"}, 64'(cq_if.rf_valid_out), 64'(tbl[i].ev));
            if (tbl[i].ev)
                check({t, ".rf_write"}, 64'({cq_if.rf_rd_out, cq_if.rf_value_out, cq_if.rf_tag_out}),
                      64'({REG_W'(tbl[i].erd), 32'(tbl[i].evl), TAG_W'(tbl[i].etg)}));
            check({t, ".count"}, 64'(cq_if.count_out), 64'(tbl[i].ecnt));
            check({t, ".cq_ready"}, 64'(cq_if.cq_ready_out), 64'(tbl[i].erdy));
            check({t, ".busy"}, 64'(cq_if.busy_out), 64'(tbl[i].ebusy));
            check({t, ".rf_flush"}, 64'(cq_if.rf_flush_out), 64'(tbl[i].efl));
        end

        // Asynchronous reset while draining with two entries still queued.
        do_reset();
        drive(1, 1, 'h101, 1, 1, 2, 'h102, 2, 0, 1); cycle("rst_seq.fill");
        drive(1, 3, 'h103, 3, 1, 4, 'h104, 4, 1, 1); cycle("rst_seq.flush");
        idle();                                     cycle("rst_seq.drain");
        check("rst_seq.pre_count", 64'(cq_if.count_out), 64'(2));
        #2;
        rst_n_in = 1'b0;
        model_clear();
        #1;
        check("rst_seq.count", 64'(cq_if.count_out), 64'(0));
        check("rst_seq.rf_valid", 64'(cq_if.rf_valid_out), 64'(0));
        check("rst_seq.rf_flush", 64'(cq_if.rf_flush_out), 64'(0));
        check("rst_seq.busy", 64'(cq_if.busy_out), 64'(0));
        check("rst_seq.cq_ready", 64'(cq_if.cq_ready_out), 64'(1));
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        for (int i = 0; i < 6; i++) cycle("rst_seq.after");

        // rdy_in low for three cycles in the middle of a drain.
        do_reset();
        drive(1, 1, 'h201, 1, 1, 2, 'h202, 2, 0, 1); cycle("rdy_seq.fill");
        drive(1, 3, 'h203, 3, 1, 4, 'h204, 4, 1, 1); cycle("rdy_seq.flush");
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 'h205, 5, 1, 6, 'h206, 6, 1, 0);
            cycle("rdy_seq.hold");
        end
        idle();
        for (int i = 0; i < 7; i++) cycle("rdy_seq.drain");

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit c0v, c1v;
            c0v = ($urandom_range(0, 1) == 1);
            c1v = c0v && ($urandom_range(0, 2) != 0);
            drive(c0v, $urandom_range(0, 31), $urandom(), $urandom_range(0, 31),
                  c1v, $urandom_range(0, 31), $urandom(), $urandom_range(0, 31),
                  ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) != 0));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
